led_adc_sequencer: RTL and testbench

- Front-end controller for the finger-clip pulse oximeter. Alternates the infrared and red LEDs every 10 ms (100 Hz alternation).
- Triggers one ADC conversion per LED phase after a settling delay, and demultiplexes the 8-bit result into separate IR and red sample registers.
- Generates `CLK_Filter`, the sample clock for the downstream IR/red FIR filters. It sits directly upstream of the FIR filter stage.

---
 rtl/oxi_pkg.sv | 20 ++
 rtl/led_adc_sequencer_if.sv | 12 +
 rtl/phase_timer.sv | 44 ++++
 rtl/led_adc_sequencer.sv | 110 +++++++++++
 tb/tb_led_adc_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/oxi_pkg.sv
// Shared types and timing defaults for the pulse-oximeter front end and the
// downstream FIR / processing stages.
package oxi_pkg;

  localparam int ADC_W              = 8;
  localparam int CLKS_PER_PHASE_DEF = 10000;
  localparam int SETTLE_CLKS_DEF    = 500;

  typedef enum logic {
    PH_IR  = 1'b0,
    PH_RED = 1'b1
  } phase_t;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_CONV   = 2'd1,
    ST_HOLD   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/led_adc_sequencer_if.sv
// ADC handshake between the LED sequencer (master) and the converter (slave).
interface led_adc_sequencer_if;
  import oxi_pkg::*;

  logic             adc_start;
  logic             adc_done;
  logic [ADC_W-1:0] adc_data;

  modport master (output adc_start, input adc_done, input adc_data);
  modport slave  (input adc_start, output adc_done, output adc_data);

endinterface

// File: rtl/phase_timer.sv
// LED phase timebase: free-running phase counter, IR/red phase flag and the
// wrap / settle strobes the sequencer FSM keys off.
module phase_timer
  import oxi_pkg::*;
#(
  parameter int CLKS_PER_PHASE = CLKS_PER_PHASE_DEF,
  parameter int SETTLE_CLKS    = SETTLE_CLKS_DEF
) (
  input  logic   clk,
  input  logic   rst,
  output logic   wrap_o,
  output logic   settle_o,
  output phase_t phase_o
);

  localparam int CNT_W = $clog2(CLKS_PER_PHASE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_t           phase_q, phase_d;

  assign wrap_o   = (cnt_q == CNT_W'(CLKS_PER_PHASE - 1));
  assign settle_o = (cnt_q == CNT_W'(SETTLE_CLKS - 1));
  assign phase_o  = phase_q;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (wrap_o) begin
      cnt_d   = '0;
      phase_d = (phase_q == PH_IR) ? PH_RED : PH_IR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= PH_IR;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/led_adc_sequencer.sv
// Pulse-oximeter front end: alternates IR/red LEDs, fires one ADC conversion
// per phase after settling, demuxes results and produces the FIR sample clock.
module led_adc_sequencer
  import oxi_pkg::*;
#(
  parameter int CLKS_PER_PHASE = CLKS_PER_PHASE_DEF,
  parameter int SETTLE_CLKS    = SETTLE_CLKS_DEF
) (
  input  logic                       CLK,
  input  logic                       rst,
  led_adc_sequencer_if.master        adc,
  output logic                       LED_IR_on,
  output logic                       LED_Red_on,
  output logic [ADC_W-1:0]           IR_ADC_Value,
  output logic [ADC_W-1:0]           Red_ADC_Value,
  output logic                       IR_valid,
  output logic                       Red_valid,
  output logic                       CLK_Filter,
  output logic                       conv_timeout
);

  logic       wrap, settle;
  phase_t     phase;
  seq_state_t state_q, state_d;

  logic             start_req, capture, timeout_set;
  logic             adc_start_q, ir_valid_q, red_valid_q, timeout_q;
  logic             led_ir_q, led_red_q, clk_filter_q;
  logic [ADC_W-1:0] ir_value_q, red_value_q;

  phase_timer #(
    .CLKS_PER_PHASE (CLKS_PER_PHASE),
    .SETTLE_CLKS    (SETTLE_CLKS)
  ) u_timer (
    .clk      (CLK),
    .rst      (rst),
    .wrap_o   (wrap),
    .settle_o (settle),
    .phase_o  (phase)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= ST_SETTLE;
    else     state_q <= state_d;
  end

  // A done landing on the wrap cycle belongs to the ending phase, so the
  // sequencer must still be back in SETTLE for the new phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SETTLE: if (settle) state_d = ST_CONV;
      ST_CONV: begin
        if (adc.adc_done) state_d = wrap ? ST_SETTLE : ST_HOLD;
        else if (wrap)    state_d = ST_SETTLE;
      end
      ST_HOLD:   if (wrap) state_d = ST_SETTLE;
      default:   state_d = ST_SETTLE;
    endcase
  end

  always_comb begin
    start_req   = 1'b0;
    capture     = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      ST_SETTLE: start_req = settle;
      ST_CONV: begin
        capture     = adc.adc_done;
        timeout_set = wrap & ~adc.adc_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      adc_start_q  <= 1'b0;
      ir_valid_q   <= 1'b0;
      red_valid_q  <= 1'b0;
      ir_value_q   <= '0;
      red_value_q  <= '0;
      timeout_q    <= 1'b0;
      led_ir_q     <= 1'b1;
      led_red_q    <= 1'b0;
      clk_filter_q <= 1'b0;
    end else begin
      adc_start_q  <= start_req;
      ir_valid_q   <= capture && (phase == PH_IR);
      red_valid_q  <= capture && (phase == PH_RED);
      if (capture && (phase == PH_IR))  ir_value_q  <= adc.adc_data;
      if (capture && (phase == PH_RED)) red_value_q <= adc.adc_data;
      if (timeout_set) timeout_q <= 1'b1;
      led_ir_q     <= (phase == PH_IR);
      led_red_q    <= (phase == PH_RED);
      clk_filter_q <= (phase == PH_RED);
    end
  end

  assign adc.adc_start  = adc_start_q;
  assign LED_IR_on      = led_ir_q;
  assign LED_Red_on     = led_red_q;
  assign IR_ADC_Value   = ir_value_q;
  assign Red_ADC_Value  = red_value_q;
  assign IR_valid       = ir_valid_q;
  assign Red_valid      = red_valid_q;
  assign CLK_Filter     = clk_filter_q;
  assign conv_timeout   = timeout_q;

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Scoreboard bench for led_adc_sequencer: a phase-plan ADC model queues the
// expected captures, a monitor compares every cycle against a timeline model.
module tb_led_adc_sequencer;

  localparam int CPP = 20;
  localparam int SET = 4;
  localparam int INF = 32'h7fff_ffff;

  typedef struct {
    int         delay;
    logic [7:0] data;
    int         spurA;
    int         spurB;
  } plan_t;

  typedef struct {
    int         chan;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic       LED_IR_on, LED_Red_on, IR_valid, Red_valid, CLK_Filter, conv_timeout;
  logic [7:0] IR_ADC_Value, Red_ADC_Value;

  led_adc_sequencer_if adcIf();

  led_adc_sequencer #(
    .CLKS_PER_PHASE (CPP),
    .SETTLE_CLKS    (SET)
  ) dut (
    .CLK           (CLK),
    .rst           (rst),
    .adc           (adcIf),
    .LED_IR_on     (LED_IR_on),
    .LED_Red_on    (LED_Red_on),
    .IR_ADC_Value  (IR_ADC_Value),
    .Red_ADC_Value (Red_ADC_Value),
    .IR_valid      (IR_valid),
    .Red_valid     (Red_valid),
    .CLK_Filter    (CLK_Filter),
    .conv_timeout  (conv_timeout)
  );

  always #5 CLK = ~CLK;

  plan_t      dirPlans[$];
  exp_t       expQ[$];
  plan_t      cur;
  int         cyc;
  int         timeoutFrom = INF;
  int         checks = 0;
  int         failures = 0;
  bit         holdOff = 1'b0;
  bit         planHeld = 1'b0;
  bit         pendingAfterReset = 1'b0;
  logic [7:0] expIr = 8'h00;
  logic [7:0] expRed = 8'h00;

  // Cycle index since the last reset release; equals the DUT phase counter
  // position modulo CPP.
  always @(posedge CLK or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Chooses how the ADC behaves during phase p; a phase with no answer
  // must raise the sticky timeout from the first cycle of the next phase.
  task automatic applyStimulus(int p);
    planHeld = 1'b0;
    if (dirPlans.size() > 0) begin
      cur = dirPlans.pop_front();
    end else if (holdOff) begin
      cur = '{-1, 8'h00, -1, -1};
      planHeld = 1'b1;
    end else begin
      cur.delay = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, CPP-1-SET));
      cur.data  = 8'($urandom);
      cur.spurA = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, SET-1)) : -1;
      cur.spurB = -1;
      if (cur.delay >= 0 && cur.delay < CPP-1-SET && $urandom_range(0, 1) == 1)
        cur.spurB = int'($urandom_range(SET + cur.delay + 1, CPP-1));
    end
    if (cur.delay < 0 && (p + 1) * CPP < timeoutFrom) timeoutFrom = (p + 1) * CPP;
  endtask

  // ADC model: drives done/data for the current cycle and queues expectations.
  always @(negedge CLK) begin
    int pos;
    if (rst) begin
      adcIf.adc_done = 1'b0;
      adcIf.adc_data = 8'h00;
      expQ.delete();
      timeoutFrom = INF;
    end else begin
      pos = cyc % CPP;
      if (pos == 0) applyStimulus(cyc / CPP);
      adcIf.adc_done = 1'b0;
      adcIf.adc_data = 8'($urandom);
      if (cur.delay >= 0 && pos == SET + cur.delay) begin
        adcIf.adc_done = 1'b1;
        adcIf.adc_data = cur.data;
        expQ.push_back('{(cyc / CPP) % 2, cur.data, cyc + 1});
      end else if (pendingAfterReset && cyc == 1) begin
        adcIf.adc_done = 1'b1;
        adcIf.adc_data = 8'hC3;
      end else if (pos == cur.spurA || pos == cur.spurB) begin
        adcIf.adc_done = 1'b1;
        adcIf.adc_data = 8'hFF;
      end
      if (cyc >= 1) pendingAfterReset = 1'b0;
    end
  end

  // Monitor: timeline expectations for LEDs/start/timeout, queue for captures.
  always @(negedge CLK) begin
    int   pos;
    int   ledPh;
    logic expIrV, expRedV;
    exp_t e;
    if (rst) begin
      expIr  = 8'h00;
      expRed = 8'h00;
    end else begin
      pos     = cyc % CPP;
      ledPh   = (cyc == 0) ? 0 : ((cyc - 1) / CPP) % 2;
      expIrV  = 1'b0;
      expRedV = 1'b0;
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        if (e.chan == 0) begin
          expIrV = 1'b1;
          expIr  = e.data;
        end else begin
          expRedV = 1'b1;
          expRed  = e.data;
        end
      end
      checkOutput("adc_start",     8'(adcIf.adc_start), 8'(pos == SET));
      checkOutput("LED_IR_on",     8'(LED_IR_on),       8'(ledPh == 0));
      checkOutput("LED_Red_on",    8'(LED_Red_on),      8'(ledPh == 1));
      checkOutput("led_exclusive", 8'(LED_IR_on & LED_Red_on), 8'h00);
      checkOutput("CLK_Filter",    8'(CLK_Filter),      8'(ledPh == 1));
      checkOutput("IR_valid",      8'(IR_valid),        8'(expIrV));
      checkOutput("Red_valid",     8'(Red_valid),       8'(expRedV));
      checkOutput("IR_ADC_Value",  IR_ADC_Value,        expIr);
      checkOutput("Red_ADC_Value", Red_ADC_Value,       expRed);
      checkOutput("conv_timeout",  8'(conv_timeout),    8'(cyc >= timeoutFrom));
    end
  end

  initial begin
    int guard;
    adcIf.adc_done = 1'b0;
    adcIf.adc_data = 8'h00;
    dirPlans.push_back('{3,          8'h5A, -1, -1});
    dirPlans.push_back('{3,          8'hA5, -1, -1});
    dirPlans.push_back('{CPP-1-SET,  8'h33, -1, -1});
    dirPlans.push_back('{-1,         8'h00, -1, -1});
    dirPlans.push_back('{3,          8'h11,  1, CPP-2});
    dirPlans.push_back('{2,          8'h77,  0, CPP-1});

    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
    repeat (30 * CPP) @(negedge CLK);

    // Reset two cycles after adc_start of a phase whose ADC answer is late.
    holdOff = 1'b1;
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (!(planHeld && (cyc % CPP) == SET + 2) && guard < 4 * CPP);
    checks++;
    if (guard >= 4 * CPP) begin
      failures++;
      $display("[TB] FAIL reset_sync_wait got=%0d expected<%0d", guard, 4 * CPP);
    end
    #1 rst = 1'b1;
    holdOff = 1'b0;
    pendingAfterReset = 1'b1;
    repeat (2) @(posedge CLK);
    #1 rst = 1'b0;
    repeat (25 * CPP) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
